// File: rtl/bet_ledger.sv
// Roulette bet ledger: records chip-backed bets from keyboard events, locks them
// during a spin, and clears the table once payout is done.
module bet_ledger #(
   parameter int MAX_BETS    = 12,
   parameter int HOLD_CYCLES = 100_000_000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  key_valid,
   input  logic [5:0]            bet_opcode,
   input  logic [2:0]            chip_color,
   input  logic                  spin_done,
   output logic [8*MAX_BETS-1:0] bets_flat,
   output logic [3:0]            bet_count,
   output logic                  bet_received,
   output logic                  spin_req,
   output logic                  reject,
   output logic [1:0]            state
);

   localparam int          TW         = $clog2(HOLD_CYCLES + 1);
   localparam logic [5:0]  OP_SPIN    = 6'b111110;
   localparam logic [5:0]  OP_CANCEL  = 6'b111111;
   localparam logic [3:0]  COUNT_MAX  = 4'(MAX_BETS);
   localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES);

   typedef enum logic [1:0] {
      OPEN  = 2'b00,
      SPIN  = 2'b01,
      CLEAR = 2'b10
   } ledgerState_e;

   ledgerState_e    stateQ, stateD;
   logic            keyValidQ;
   logic [3:0]      countQ, countD;
   logic [7:0]      slotQ [MAX_BETS];
   logic [7:0]      slotD [MAX_BETS];
   logic [TW-1:0]   holdQ, holdD;
   logic            rejectQ, rejectD;

   logic keyEdge, isSpinKey, isCancelKey, isBetKey;
   logic accept, wipe;

   // The keyboard level can be held for many cycles, so only its rising edge counts.
   assign keyEdge     = key_valid & ~keyValidQ;
   assign isSpinKey   = (bet_opcode == OP_SPIN);
   assign isCancelKey = (bet_opcode == OP_CANCEL);
   assign isBetKey    = ~isSpinKey & ~isCancelKey;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stateQ <= OPEN;
      end else begin
         stateQ <= stateD;
      end
   end

   // Next-state and ledger update; a refused bet only raises reject and touches nothing else.
   always_comb begin
      stateD  = stateQ;
      countD  = countQ;
      slotD   = slotQ;
      holdD   = (holdQ != '0) ? holdQ - TW'(1) : holdQ;
      rejectD = 1'b0;
      accept  = 1'b0;
      wipe    = 1'b0;

      unique case (stateQ)
         OPEN: begin
            if (keyEdge && isBetKey) begin
               if (chip_color[2] && (countQ < COUNT_MAX)) begin
                  accept = 1'b1;
               end else begin
                  rejectD = 1'b1;
               end
            end else if (keyEdge && isSpinKey && (countQ != 4'd0)) begin
               stateD = SPIN;
            end else if (keyEdge && isCancelKey) begin
               wipe = 1'b1;
            end
         end
         SPIN: begin
            rejectD = keyEdge & isBetKey;
            if (spin_done) begin
               stateD = CLEAR;
               wipe   = 1'b1;
            end
         end
         CLEAR: begin
            rejectD = keyEdge & isBetKey;
            stateD  = OPEN;
            wipe    = 1'b1;
         end
         default: begin
            stateD = OPEN;
         end
      endcase

      if (accept) begin
         for (int i = 0; i < MAX_BETS; i++) begin
            if (countQ == 4'(i)) begin
               slotD[i] = {chip_color[1:0], bet_opcode};
            end
         end
         countD = countQ + 4'd1;
         holdD  = HOLD_LOAD;
      end

      // Leaving SPIN wipes on the same edge, so the slots never change while spinning.
      if (wipe) begin
         for (int i = 0; i < MAX_BETS; i++) begin
            slotD[i] = 8'h00;
         end
         countD = 4'd0;
         holdD  = '0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         keyValidQ <= 1'b0;
         countQ    <= 4'd0;
         holdQ     <= '0;
         rejectQ   <= 1'b0;
         for (int i = 0; i < MAX_BETS; i++) begin
            slotQ[i] <= 8'h00;
         end
      end else begin
         keyValidQ <= key_valid;
         countQ    <= countD;
         holdQ     <= holdD;
         rejectQ   <= rejectD;
         for (int i = 0; i < MAX_BETS; i++) begin
            slotQ[i] <= slotD[i];
         end
      end
   end

   always_comb begin
      bets_flat = '0;
      for (int i = 0; i < MAX_BETS; i++) begin
         bets_flat[8*i +: 8] = slotQ[i];
      end
   end

   assign bet_count    = countQ;
   assign bet_received = (holdQ != '0);
   assign spin_req     = (stateQ == SPIN);
   assign reject       = rejectQ;
   assign state        = stateQ;

endmodule

// File: doc/bet_ledger.md
BET_LEDGER -- requirements
Module: bet_ledger

Interface
REQ-001 SHALL have parameter MAX_BETS, default 12: number of bet slots.
REQ-002 SHALL have parameter HOLD_CYCLES, default 100_000_000: bet_received hold time in clocks (2 s at 50 MHz).
REQ-003 clock  in  1  system clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 key_valid  in  1  PS/2 "byte received" level from the keyboard controller; may stay high for many cycles.
REQ-006 bet_opcode  in  6  decoded key: 0-36 number bets, other codes outside the reserved set are group bets, 6'b111110 = SPIN, 6'b111111 = CANCEL.
REQ-007 chip_color  in  3  Arduino chip sensor: bit2 = chip present, bits[1:0] = chip value code.
REQ-008 spin_done  in  1  one-cycle pulse from the processor side when payout for the current spin is complete.
REQ-009 bets_flat  out  8*MAX_BETS  slot i at [8i+7:8i] = {chip_color[1:0], bet_opcode}; unused slots are 0.
REQ-010 bet_count  out  4  number of valid slots, 0..MAX_BETS.
REQ-011 bet_received  out  1  high for HOLD_CYCLES after each accepted bet.
REQ-012 spin_req  out  1  high for the whole SPIN state; drives the wheel and spin_check.
REQ-013 reject  out  1  one-cycle pulse when a bet key is refused.
REQ-014 state  out  2  00 OPEN, 01 SPIN, 10 CLEAR.

Function
REQ-015 SHALL register key_valid and act only on its rising edge (key_edge = key_valid & ~key_valid_q); a held level SHALL produce exactly one event.
REQ-016 Bet key: key_edge, opcode not 111110/111111. It SHALL be accepted only in OPEN with chip_color[2]=1 and bet_count<MAX_BETS.
REQ-017 On an accepted bet, the bet SHALL be written to slot bet_count and bet_count SHALL increment, both visible the cycle after the edge.
REQ-018 Slot writes SHALL change no other slot.
REQ-019 A bet key refused for full ledger, chip_color[2]=0, or state not OPEN SHALL assert reject for one cycle and SHALL change no state.
REQ-020 Full ledger is bet_count==MAX_BETS. bet_count SHALL saturate and never wrap.
REQ-021 FSM OPEN->SPIN on SPIN key edge when bet_count>0. A SPIN key edge with bet_count==0 SHALL be ignored, with no reject.
REQ-022 FSM SPIN->CLEAR on spin_done. Key edges in SPIN SHALL be ignored, except bet keys, which SHALL pulse reject.
REQ-023 FSM CLEAR->OPEN unconditionally after 1 cycle. In CLEAR all slots and bet_count SHALL be zeroed.
REQ-024 CANCEL key edge in OPEN SHALL zero all slots and bet_count next cycle, staying in OPEN. CANCEL outside OPEN SHALL be ignored.
REQ-025 spin_done outside SPIN SHALL be ignored.
REQ-026 bets_flat SHALL remain stable for the whole of SPIN, for downstream payout use.
REQ-027 Hold timer: on an accepted bet, counter loads HOLD_CYCLES and bet_received goes high next cycle.
REQ-028 Hold timer: counter decrements each cycle while nonzero; bet_received drops when counter reaches 0.
REQ-029 Hold timer: a new accepted bet SHALL reload the counter (retrigger).
REQ-030 Hold timer: CANCEL or CLEAR SHALL zero the counter and drop bet_received.
REQ-031 Timer width SHALL be $clog2(HOLD_CYCLES+1). Count arithmetic SHALL be unsigned with no overflow.

Reset
REQ-032 Reset asserted at any time, including mid-SPIN, SHALL immediately force:
- state OPEN;
- all slots 0, bet_count 0;
- spin_req 0, bet_received 0, reject 0;
- hold counter 0, key_valid_q 0.
REQ-033 The first clock edge after reset deassertion SHALL take no action unless key_valid is high at that edge (a rising edge relative to key_valid_q=0).

Verification (bench uses HOLD_CYCLES=4, MAX_BETS=12)
REQ-034 Bet accepted: chip_color=3'b110, opcode=17, key_valid high for 10 cycles.
- bet_count=1, bets_flat[7:0]=8'h91;
- bet_received high exactly 4 cycles;
- no second entry from the held key.
REQ-035 Full ledger: 12 accepted bets, then a 13th key.
- reject pulses once;
- bet_count stays 12, slot 11 unchanged.
REQ-036 Spin cycle: 2 bets, SPIN key.
- state=01, spin_req=1;
- a bet key now gives reject and count stays 2;
- spin_done pulse gives state 10 for one cycle, then 00 with bet_count=0 and bets_flat=0.
REQ-037 Guard cases:
- SPIN key with 0 bets: state stays 00;
- bet key with chip_color=3'b001: reject, count unchanged.
REQ-038 CANCEL and retrigger: 3 bets then CANCEL gives count 0 and bet_received 0; two bets 2 cycles apart give bet_received high for 6 cycles total.
REQ-039 Reset mid-SPIN: all outputs return to their reset values asynchronously, before the next clock edge.
